// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaled period counter, double-buffered duties,
// and an optional per-channel phase stagger. All state updates on the rising edge of clk.
module pwm_multi_gen #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8,
    parameter int PRESC    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        stagger,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(CHANNELS):0]   wr_chan,
    input  logic [CNT_W:0]              wr_duty,
    output logic                        wr_err,
    output logic [CHANNELS-1:0]         pwm,
    output logic                        period_tick
);

    localparam int                CH_W    = $clog2(CHANNELS);
    localparam int                PS_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W:0]    FULL    = {1'b1, {CNT_W{1'b0}}};
    localparam int                PH_STEP = (1 << CNT_W) / CHANNELS;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              period_tick_q, period_tick_d;
    logic              wr_err_q, wr_err_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CNT_W:0]    shadow_q [CHANNELS];
    logic [CNT_W:0]    shadow_d [CHANNELS];
    logic [CNT_W:0]    active_q [CHANNELS];
    logic [CNT_W:0]    active_d [CHANNELS];
    logic              act_stag_q, act_stag_d;

    logic              tick;
    logic              wr_acc;
    logic              chan_ok;
    logic              eff_stag;
    logic [CNT_W:0]    duty_clamp;

    assign wr_ready   = !rst;
    assign tick       = en && (presc_q == PS_LAST);
    assign wr_acc     = wr_valid && wr_ready;
    assign chan_ok    = (wr_chan < (CH_W + 1)'(CHANNELS));
    assign duty_clamp = (wr_duty > FULL) ? FULL : wr_duty;
    // On the commit cycle the comparators see the incoming values, so a new period starts clean.
    assign eff_stag   = period_tick_q ? stagger : act_stag_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
        presc_d       = presc_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        act_stag_d    = act_stag_q;
        period_tick_d = tick && (cnt_q == CNT_MAX);
        wr_err_d      = wr_acc && !chan_ok;
        pwm_d         = '0;

        if (!en) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            presc_d = presc_q + PS_W'(1);
        end

        if (wr_acc && chan_ok) begin
            shadow_d[wr_chan[CH_W-1:0]] = duty_clamp;
        end

        if (period_tick_q) begin
            active_d   = shadow_q;
            act_stag_d = stagger;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = en && ({1'b0, cnt_q + (eff_stag ? CNT_W'(i * PH_STEP) : CNT_W'(0))}
                              < (period_tick_q ? shadow_q[i] : active_q[i]));
        end
    end

    // NOTE: the duty arrays are reset too, because a reset must leave every channel at duty 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            cnt_q         <= '0;
            period_tick_q <= 1'b0;
            wr_err_q      <= 1'b0;
            pwm_q         <= '0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            act_stag_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            period_tick_q <= period_tick_d;
            wr_err_q      <= wr_err_d;
            pwm_q         <= pwm_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            act_stag_q    <= act_stag_d;
        end
    end

    assign pwm         = pwm_q;
    assign period_tick = period_tick_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: a PRESC=1 instance exercises writes, commit, clamp and stagger;
// a PRESC=3 instance exercises prescaling, enable drop and mid-period reset.
module tb_pwm_multi_gen;

    logic       clk;
    logic       rst, en, stagger, wr_valid, wr_ready, wr_err, period_tick;
    logic [2:0] wr_chan;
    logic [4:0] wr_duty;
    logic [3:0] pwm;

    logic       rst3, en3, stagger3, wr_valid3, wr_ready3, wr_err3, period_tick3;
    logic [3:0] pwm3;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_multi_gen #(.CHANNELS(4), .CNT_W(4), .PRESC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .stagger(stagger),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_duty(wr_duty),
        .wr_err(wr_err), .pwm(pwm), .period_tick(period_tick)
    );

    pwm_multi_gen #(.CHANNELS(4), .CNT_W(4), .PRESC(3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .stagger(stagger3),
        .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_chan(wr_chan), .wr_duty(wr_duty),
        .wr_err(wr_err3), .pwm(pwm3), .period_tick(period_tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Staggered pattern for duty 4 on every channel: channel i sees (cnt + 4i) mod 16.
    function automatic logic [3:0] stag_exp(input int ph);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (((ph + 4 * i) % 16) < 4);
        return r;
    endfunction

    initial begin
        logic [3:0] e;
        int         ph;

        rst = 1; en = 0; stagger = 0; wr_valid = 1; wr_chan = 3'd1; wr_duty = 5'd8;
        rst3 = 1; en3 = 0; stagger3 = 0; wr_valid3 = 0;

        // Reset held for three cycles with a write on ch1 that must be dropped.
        repeat (3) begin
            @(negedge clk);
            check("rst_pwm", 32'(pwm), 32'h0);
            check("rst_period_tick", 32'(period_tick), 32'h0);
            check("rst_wr_err", 32'(wr_err), 32'h0);
            check("rst_wr_ready", 32'(wr_ready), 32'h0);
        end
        rst = 0; en = 1; wr_valid = 0;

        // Cycle c: cnt = c mod 16; pwm reflects cnt of the previous cycle.
        for (int c = 1; c <= 112; c++) begin
            @(negedge clk);
            ph = (c + 15) % 16;
            if (c <= 32)      e = 4'b0000;
            else if (c <= 48) e = {3'b000, ph < 4};
            else if (c <= 80) e = {1'b1, 1'b1, 1'b0, ph < 4};
            else if (c <= 96) e = {1'b1, 1'b1, ph < 8, ph < 4};
            else              e = stag_exp(ph);
            check($sformatf("pwm_c%0d", c), 32'(pwm), 32'(e));
            check($sformatf("period_tick_c%0d", c), 32'(period_tick), 32'(c % 16 == 0));
            check($sformatf("wr_err_c%0d", c), 32'(wr_err), 32'((c == 51) || (c == 53)));
            if (c > 96) check($sformatf("stag_onehot_c%0d", c), 32'($countones(pwm)), 32'd1);
            if (c == 97)  check("stag_ph0", 32'(pwm), 32'h1);
            if (c == 101) check("stag_ph4", 32'(pwm), 32'h8);
            if (c == 105) check("stag_ph8", 32'(pwm), 32'h4);
            if (c == 109) check("stag_ph12", 32'(pwm), 32'h2);
            if (c == 2)   check("wr_ready_run", 32'(wr_ready), 32'h1);

            wr_valid = 0;
            case (c)
                20: begin wr_valid = 1; wr_chan = 3'd0; wr_duty = 5'd4;  end
                36: begin wr_valid = 1; wr_chan = 3'd1; wr_duty = 5'd0;  end
                37: begin wr_valid = 1; wr_chan = 3'd2; wr_duty = 5'd16; end
                38: begin wr_valid = 1; wr_chan = 3'd3; wr_duty = 5'd20; end
                50: begin wr_valid = 1; wr_chan = 3'd4; wr_duty = 5'd2;  end
                52: begin wr_valid = 1; wr_chan = 3'd5; wr_duty = 5'd9;  end
                64: begin wr_valid = 1; wr_chan = 3'd1; wr_duty = 5'd8;  end
                82, 83, 84, 85: begin wr_valid = 1; wr_chan = 3'(c - 82); wr_duty = 5'd4; end
                90: stagger = 1;
                default: ;
            endcase
        end

        // PRESC=3 instance: cnt advances every third cycle, period is 48 cycles.
        rst3 = 0; en3 = 1; wr_valid3 = 1; wr_chan = 3'd0; wr_duty = 5'd8;
        for (int k = 1; k <= 190; k++) begin
            @(negedge clk);
            if (k <= 48)       e = 4'b0000;
            else if (k <= 80)  e = {2'b00, 1'b1, (((k - 1) / 3) % 16) < 8};
            else if (k <= 82)  e = 4'b0000;
            else if (k <= 140) e = {2'b00, 1'b1, (((k - 83) / 3) % 16) < 8};
            else               e = 4'b0000;
            check($sformatf("p3_pwm_k%0d", k), 32'(pwm3), 32'(e));
            check($sformatf("p3_period_tick_k%0d", k), 32'(period_tick3),
                  32'((k == 48) || (k == 130) || (k == 189)));
            check($sformatf("p3_wr_err_k%0d", k), 32'(wr_err3), 32'h0);
            check($sformatf("p3_wr_ready_k%0d", k), 32'(wr_ready3), 32'(k != 141));

            case (k)
                1:   begin wr_valid3 = 1; wr_chan = 3'd1; wr_duty = 5'd16; end
                2:   wr_valid3 = 0;
                80:  en3 = 0;
                82:  en3 = 1;
                140: rst3 = 1;
                141: rst3 = 0;
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
